song_recorder: RTL and testbench

- Captures live keyboard performance into an on-chip song buffer, as {octave, note, duration} entries.
- It is the writer side of the song-memory interface; the auto-play/learning playback path is the reader.
- Sits beside the free-play piano and taps the same key_in/octave_keys inputs.
- Exposes a synchronous read port and a length count so a playback controller can replay the recorded song.

---
 rtl/song_recorder.sv | 180 ++++++++++++++++++
 tb/tb_song_recorder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/song_recorder.sv
// song_recorder: captures live keyboard play into an on-chip song buffer.
// Each buffer entry is {octave[13:12], note[11:8], dur[7:0]}. The duration
// unit is one TICK_MS tick. A playback controller reads the buffer back through
// a registered read port and uses rec_len to know how many entries are valid.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   record_en    record switch (level); a rising edge starts a new take
//   key_in       note keys, bit i = note i+1
//   octave_keys  octave select, stored verbatim
//   rd_addr      playback read address
//   rd_data      registered read data, 0 beyond rec_len
//   rec_len      number of valid entries (0..DEPTH)
//   recording    high while arming or capturing
//   full         high once the buffer has filled during a take
module song_recorder #(
  parameter int CLK_HZ      = 100000000,
  parameter int TICK_MS     = 10,
  parameter int DEBOUNCE_MS = 20,
  parameter int DEPTH       = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          record_en,
  input  logic [6:0]    key_in,
  input  logic [1:0]    octave_keys,
  input  logic [AW-1:0] rd_addr,
  output logic [13:0]   rd_data,
  output logic [AW:0]   rec_len,
  output logic          recording,
  output logic          full
);

  // Divide before multiplying so large clocks do not overflow 32-bit math.
  localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int TICK_CYC = (CLK_HZ / 1000) * TICK_MS;
  localparam int DB_W     = $clog2(DB_CYC + 1);
  localparam int TK_W     = $clog2(TICK_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_FULL    = 2'd3;

  logic [1:0]      state;
  logic            rec_q;
  logic [8:0]      cand, db;
  logic [DB_W-1:0] db_cnt;
  logic [TK_W-1:0] tcnt;
  logic            tick;
  logic [3:0]      db_note;
  logic [5:0]      key_now;
  logic [5:0]      cur;
  logic [7:0]      dur;
  logic [AW-1:0]   wr_ptr;
  logic            we;
  logic [13:0]     wdata;
  logic            enter_cap;
  logic [13:0]     mem [DEPTH];

  // Debounce the whole 9-bit sample as one unit: any change restarts the
  // stability count. The sample is accepted once the count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand   <= '0;
      db     <= '0;
      db_cnt <= '0;
    end else if ({octave_keys, key_in} != cand) begin
      cand   <= {octave_keys, key_in};
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
      db <= cand;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Lowest pressed key wins: scan downward so the last hit is the lowest.
  always_comb begin
    db_note = 4'd0;
    for (int i = 6; i >= 0; i--)
      if (db[i]) db_note = 4'(i + 1);
  end

  assign key_now   = {db[8:7], db_note};
  assign enter_cap = (state == S_ARM) && record_en && (db_note != 4'd0);

  // Free-running tick. It is re-phased on CAPTURE entry so that the first
  // duration step lands a full tick after the first note starts.
  assign tick = (tcnt == TK_W'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         tcnt <= '0;
    else if (enter_cap) tcnt <= '0;
    else if (tick)      tcnt <= '0;
    else                tcnt <= tcnt + 1'b1;
  end

  // Write decision. A note change takes priority over a tick, so a change at
  // a saturated duration produces one write of {cur, 255}.
  always_comb begin
    we    = 1'b0;
    wdata = {cur, dur};
    if (state == S_CAPTURE) begin
      if (!record_en)                  we = (cur[3:0] != 4'd0);
      else if (key_now != cur)         we = 1'b1;
      else if (tick && dur == 8'hFF)   we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      rec_q   <= 1'b0;
      cur     <= '0;
      dur     <= '0;
      wr_ptr  <= '0;
      rec_len <= '0;
    end else begin
      rec_q <= record_en;
      case (state)
        S_IDLE: begin
          if (record_en && !rec_q) begin
            wr_ptr  <= '0;
            rec_len <= '0;
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          // Leading silence is skipped; the take starts on the first note.
          if (!record_en) begin
            rec_len <= '0;
            state   <= S_IDLE;
          end else if (db_note != 4'd0) begin
            cur   <= key_now;
            dur   <= 8'd1;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!record_en) begin
            state <= S_IDLE;
          end else begin
            if (key_now != cur) begin
              cur <= key_now;
              dur <= 8'd1;
            end else if (tick) begin
              dur <= (dur == 8'hFF) ? 8'd1 : dur + 8'd1;
            end
            if (we && rec_len == (AW+1)'(DEPTH - 1)) state <= S_FULL;
          end
        end
        default: begin
          if (!record_en) state <= S_IDLE;
        end
      endcase
      if (we) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rec_len <= rec_len + 1'b1;
      end
    end
  end

  // Buffer storage carries no reset; validity is tracked by rec_len alone.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          rd_data <= '0;
    else if ({1'b0, rd_addr} < rec_len)  rd_data <= mem[rd_addr];
    else                                 rd_data <= '0;
  end

  assign recording = (state == S_ARM) || (state == S_CAPTURE);
  assign full      = (state == S_FULL);

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder using a 10-cycle tick and a 10-cycle debounce.
module tb_song_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        record_en;
  logic [6:0]  key_in;
  logic [1:0]  octave_keys;
  logic [5:0]  rd_addr;
  logic [13:0] rd_data;
  logic [6:0]  rec_len;
  logic        recording;
  logic        full;

  int n_chk = 0;
  int n_err = 0;

  song_recorder #(
    .CLK_HZ(10000), .TICK_MS(1), .DEBOUNCE_MS(1), .DEPTH(64), .AW(6)
  ) dut (
    .clk(clk), .reset(reset), .record_en(record_en), .key_in(key_in),
    .octave_keys(octave_keys), .rd_addr(rd_addr), .rd_data(rd_data),
    .rec_len(rec_len), .recording(recording), .full(full)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input int lo, input int hi);
    n_chk++;
    assert (!$isunknown(obs) && obs >= lo && obs <= hi)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic rd(input int a);
    rd_addr = 6'(a);
    step(1);
  endtask

  initial begin
    reset = 1'b0; record_en = 1'b0; key_in = '0; octave_keys = '0; rd_addr = '0;

    // 1. Reset state
    step(3);
    reset = 1'b1;
    step(1);
    chk("rst_len", rec_len, 0);
    chk("rst_recording", recording, 0);
    chk("rst_full", full, 0);
    rd(0);
    chk("rst_rd0", rd_data, 0);

    // 2. Two notes: key1 for 55 cycles, key3 for 30 cycles
    record_en = 1'b1; key_in = 7'b0000001; octave_keys = 2'b01;
    step(2);
    chk("t2_recording", recording, 1);
    step(53);
    key_in = 7'b0000100;
    step(30);
    record_en = 1'b0;
    step(3);
    chk("t2_len", rec_len, 2);
    chk("t2_recording_off", recording, 0);
    rd(0);
    chk("t2_e0_oct_note", rd_data[13:8], {2'b01, 4'd1});
    chk_rng("t2_e0_dur", rd_data[7:0], 5, 6);
    rd(1);
    chk("t2_e1_oct_note", rd_data[13:8], {2'b01, 4'd3});
    chk_rng("t2_e1_dur", rd_data[7:0], 3, 4);
    rd(2);
    chk("t2_rd_past_len", rd_data, 0);

    // 3. Leading and trailing rests are dropped
    key_in = '0;
    step(15);
    record_en = 1'b1;
    step(100);
    chk("t3_arm_len", rec_len, 0);
    key_in = 7'b0000010;
    step(50);
    key_in = '0;
    step(40);
    chk("t3_len_mid", rec_len, 1);
    record_en = 1'b0;
    step(3);
    chk("t3_len", rec_len, 1);
    rd(0);
    chk("t3_e0_oct_note", rd_data[13:8], {2'b01, 4'd2});
    chk_rng("t3_e0_dur", rd_data[7:0], 4, 6);

    // 4. Two keys held 3000 cycles: lowest wins, duration saturates at 255
    key_in = '0;
    step(15);
    record_en = 1'b1; key_in = 7'b0000011;
    step(3000);
    record_en = 1'b0;
    step(3);
    chk("t4_len", rec_len, 2);
    rd(0);
    chk("t4_e0", rd_data, {2'b01, 4'd1, 8'd255});
    rd(1);
    chk("t4_e1_oct_note", rd_data[13:8], {2'b01, 4'd1});
    chk_rng("t4_e1_dur", rd_data[7:0], 40, 48);

    // 5. Alternate note1/note4 every 20 cycles, 70 presses -> buffer fills
    key_in = '0;
    step(15);
    record_en = 1'b1; octave_keys = 2'b10;
    for (int i = 0; i < 70; i++) begin
      key_in = (i % 2 == 0) ? 7'b0000001 : 7'b0001000;
      step(20);
    end
    step(15);
    chk("t5_full", full, 1);
    chk("t5_recording", recording, 0);
    chk("t5_len", rec_len, 64);
    rd(0);
    chk("t5_e0_oct_note", rd_data[13:8], {2'b10, 4'd1});
    rd(62);
    chk("t5_e62_oct_note", rd_data[13:8], {2'b10, 4'd1});
    rd(63);
    chk("t5_e63_oct_note", rd_data[13:8], {2'b10, 4'd4});
    chk_rng("t5_e63_dur", rd_data[7:0], 2, 3);
    record_en = 1'b0;
    step(2);
    chk("t5_full_off", full, 0);
    chk("t5_idle_recording", recording, 0);
    chk("t5_len_held", rec_len, 64);

    // 6. Reset in the middle of a capture
    key_in = '0; octave_keys = 2'b00;
    step(15);
    record_en = 1'b1; key_in = 7'b0000001;
    step(30);
    key_in = 7'b0010000;
    step(25);
    chk("t6_recording", recording, 1);
    chk("t6_len_mid", rec_len, 1);
    rd(0);
    chk("t6_read_during_cap", rd_data[13:8], {2'b00, 4'd1});
    reset = 1'b0;
    #2;
    chk("t6_async_len", rec_len, 0);
    chk("t6_async_recording", recording, 0);
    record_en = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);
    chk("t6_len", rec_len, 0);
    chk("t6_recording_off", recording, 0);
    chk("t6_full", full, 0);
    rd(0);
    chk("t6_rd0", rd_data, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
